// File: rtl/cv32e40p_popcnt_ctrl.sv
// cv32e40p_popcnt_ctrl: round-robin sequencer sharing one popcount datapath between N_REQ burst requesters
// Ports: clk, rst_n (async active-low); req_i/req_len_i/gnt_o burst request, length and one-hot grant;
//        data_valid_i/data_i/data_ready_o per-requester word stream; pc_operand_o/pc_count_i shared popcount;
//        result_valid_o/result_o/result_id_o/result_ready_i burst total channel; busy_o high outside IDLE.
// Option: CV32E40P_POPCNT_CTRL_PIPE_EN registers pc_count_i before accumulation (+1 cycle result latency).
module cv32e40p_popcnt_ctrl #(
   parameter int N_REQ   = 2,
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN+1),
   parameter int ACC_W   = LEN_W+6,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_i,
   input  logic [N_REQ-1:0][LEN_W-1:0]  req_len_i,
   input  logic [N_REQ-1:0]             data_valid_i,
   input  logic [N_REQ-1:0][31:0]       data_i,
   output logic [N_REQ-1:0]             data_ready_o,
   output logic [N_REQ-1:0]             gnt_o,
   output logic [31:0]                  pc_operand_o,
   input  logic [5:0]                   pc_count_i,
   output logic                         result_valid_o,
   output logic [ACC_W-1:0]             result_o,
   output logic [ID_W-1:0]              result_id_o,
   input  logic                         result_ready_i,
   output logic                         busy_o
);
   typedef enum logic [1:0] {IDLE, STREAM, RESP} state_e;
   state_e            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]   id_q, id_d, rr_q, rr_d, win_id, cand;
   logic [LEN_W-1:0]  rem_q, rem_d, win_len;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              rdy, hs, add_en, done;
   logic [5:0]        add_val;
   // lowest offset from the rr pointer wins, so scan offsets high-to-low and let the last hit stand
   always_comb begin
      win_id = '0;
      cand   = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         cand = ID_W'((int'(rr_q) + i) % N_REQ);
         if (req_i[cand]) win_id = cand;
      end
      win_len = (req_len_i[win_id] > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i[win_id];
   end
   // rem_q reaches 0 inside STREAM only while the piped final count drains; no word is taken then
   assign rdy            = (state_q == STREAM) && (rem_q != '0);
   assign hs             = rdy && data_valid_i[id_q];
   assign data_ready_o   = rdy ? (N_REQ'(1) << id_q) : '0;
   assign pc_operand_o   = (state_q == STREAM) ? data_i[id_q] : '0;
   assign gnt_o          = gnt_q;
   assign result_valid_o = (state_q == RESP);
   assign result_o       = acc_q;
   assign result_id_o    = id_q;
   assign busy_o         = (state_q != IDLE);
`ifdef CV32E40P_POPCNT_CTRL_PIPE_EN
   logic [5:0] cnt_q, cnt_d;
   logic       cnt_vld_q, cnt_vld_d;
   always_comb begin
      cnt_d     = pc_count_i;
      cnt_vld_d = hs;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q     <= '0;
         cnt_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cnt_vld_q <= cnt_vld_d;
      end
   assign add_en  = cnt_vld_q;
   assign add_val = cnt_q;
   assign done    = (rem_q == '0);
`else
   assign add_en  = hs;
   assign add_val = pc_count_i;
   assign done    = hs && (rem_q == LEN_W'(1));
`endif
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      rr_d    = rr_q;
      rem_d   = hs ? rem_q - LEN_W'(1) : rem_q;
      acc_d   = add_en ? acc_q + ACC_W'(add_val) : acc_q;
      if (state_q == IDLE && |req_i) begin
         gnt_d   = N_REQ'(1) << win_id;
         id_d    = win_id;
         rem_d   = win_len;
         acc_d   = '0;
         state_d = (win_len == '0) ? RESP : STREAM;
      end
      if (state_q == STREAM && done) state_d = RESP;
      if (state_q == RESP && result_ready_i) begin
         state_d = IDLE;
         gnt_d   = '0;
         rr_d    = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         rr_q    <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
      end
endmodule

// File: tb/tb_cv32e40p_popcnt_ctrl.sv
// tb_cv32e40p_popcnt_ctrl: table, directed and randomized checks of the shared popcount sequencer
module tb_cv32e40p_popcnt_ctrl;
   localparam int N  = 2;
   localparam int ML = 8;
   localparam int LW = $clog2(ML+1);
   localparam int AW = LW+6;
   localparam int IW = $clog2(N);
`ifdef CV32E40P_POPCNT_CTRL_PIPE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif
   logic                  clk = 0, rst_n = 0;
   logic [N-1:0]          req_i = '0, data_valid_i = '0, data_ready_o, gnt_o;
   logic [N-1:0][LW-1:0]  req_len_i = '0;
   logic [N-1:0][31:0]    data_i = '0;
   logic [31:0]           pc_operand_o;
   logic [5:0]            pc_count_i;
   logic                  result_valid_o, result_ready_i = 0, busy_o;
   logic [AW-1:0]         result_o;
   logic [IW-1:0]         result_id_o;
   int                    vecs = 0, errs = 0;

   always #5 clk = ~clk;
   assign pc_count_i = 6'($countones(pc_operand_o));

   cv32e40p_popcnt_ctrl #(.N_REQ(N), .MAX_LEN(ML)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_len_i(req_len_i),
      .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
      .gnt_o(gnt_o), .pc_operand_o(pc_operand_o), .pc_count_i(pc_count_i),
      .result_valid_o(result_valid_o), .result_o(result_o), .result_id_o(result_id_o),
      .result_ready_i(result_ready_i), .busy_o(busy_o));

   typedef struct {
      int          r;
      int          len;
      logic [31:0] w0, w1, w2, fill;
      int          exp;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 0;
      req_i = '0;
      data_valid_i = '0;
      result_ready_i = 0;
      #3 rst_n = 1;
      tick();
   endtask

   function automatic logic [31:0] word(input vec_t v, input int n);
      return n == 0 ? v.w0 : n == 1 ? v.w1 : n == 2 ? v.w2 : v.fill;
   endfunction

   function automatic int winner(input logic [N-1:0] rq, input int p);
      for (int i = 0; i < N; i++) if (rq[(p+i)%N]) return (p+i)%N;
      return 0;
   endfunction

   task automatic run_burst(input vec_t v);
      int n = 0, since = 0, cyc = 0, want;
      logic hs;
      want = v.len > ML ? ML : v.len;
      req_i[v.r] = 1;
      req_len_i[v.r] = LW'(v.len);
      data_valid_i[v.r] = 1;
      data_i[v.r] = word(v, 0);
      tick();
      chk("tv_gnt", gnt_o, N'(1) << v.r);
      req_i[v.r] = 0;
      if (want == 0) chk("tv_len0_rdy", data_ready_o, 0);
      while (!result_valid_o && cyc < 40) begin
         hs = data_ready_o[v.r] & data_valid_i[v.r];
         tick();
         cyc++;
         if (hs) begin
            n++;
            since = 0;
            data_i[v.r] = word(v, n);
         end else since++;
      end
      chk("tv_valid", result_valid_o, 1);
      chk("tv_words", n, want);
      chk("tv_latency", since, want == 0 ? 0 : LAT);
      chk("tv_result", result_o, v.exp);
      chk("tv_id", result_id_o, v.r);
      data_valid_i[v.r] = 0;
      result_ready_i = 1;
      tick();
      result_ready_i = 0;
      chk("tv_idle", {busy_o, gnt_o}, 0);
   endtask

   initial begin
      #2 chk("reset_outputs", {gnt_o, data_ready_o, result_valid_o, result_o, result_id_o, busy_o, pc_operand_o}, 0);
      #1 rst_n = 1;
      tick();
      tv[0] = '{0, 3,  32'hFFFFFFFF, 32'h00000001, 32'h0000000F, 32'h0, 37};
      tv[1] = '{1, 1,  32'h80000000, 32'h0, 32'h0, 32'h0, 1};
      tv[2] = '{0, 0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
      tv[3] = '{1, 15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 256};
      tv[4] = '{0, 8,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 128};
      tv[5] = '{1, 2,  32'h00000000, 32'h12345678, 32'h0, 32'h0, 13};
      tv[6] = '{0, 9,  32'h00000007, 32'h00000007, 32'h00000007, 32'h00000007, 24};
      tv[7] = '{1, 4,  32'h7FFFFFFF, 32'h00000003, 32'h00000100, 32'hFFFF0000, 50};
      foreach (tv[i]) run_burst(tv[i]);

      // round-robin with both requesting continuously
      do_reset();
      req_i = '1;
      req_len_i[0] = LW'(1);
      req_len_i[1] = LW'(1);
      data_i[0] = 32'h80000000;
      data_i[1] = 32'h80000000;
      data_valid_i = '1;
      for (int k = 0; k < 4; k++) begin
         int cyc = 0;
         while (!result_valid_o && cyc < 20) begin
            tick();
            cyc++;
         end
         chk("rr_gnt", gnt_o, (k % 2) ? 2'b10 : 2'b01);
         chk("rr_id", result_id_o, k % 2);
         chk("rr_result", result_o, 1);
         result_ready_i = 1;
         tick();
         result_ready_i = 0;
      end
      req_i = '0;
      data_valid_i = '0;
      tick();

      // valid 1,0,0,1 then result held off for 5 cycles
      req_i[0] = 1;
      req_len_i[0] = LW'(2);
      data_i[0] = 32'h000000FF;
      data_valid_i[0] = 1;
      tick();
      req_i = '0;
      chk("bp_gnt", gnt_o, 2'b01);
      tick();
      data_i[0] = 32'hF0F0F0F0;
      data_valid_i[0] = 0;
      tick();
      tick();
      chk("bp_stall", {result_valid_o, busy_o, data_ready_o}, {1'b0, 1'b1, 2'b01});
      data_valid_i[0] = 1;
      tick();
      data_valid_i[0] = 0;
      repeat (LAT) tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold", {result_valid_o, busy_o, result_id_o, result_o}, {1'b1, 1'b1, 1'b0, AW'(24)});
         tick();
      end
      result_ready_i = 1;
      tick();
      result_ready_i = 0;
      chk("bp_idle", busy_o, 0);

      // reset in the middle of a burst owned by requester 1 (pointer is 1 here)
      req_i[1] = 1;
      req_len_i[1] = LW'(4);
      data_i[1] = 32'hFFFFFFFF;
      data_valid_i[1] = 1;
      tick();
      req_i = '0;
      chk("mr_gnt", gnt_o, 2'b10);
      tick();
      #2 rst_n = 0;
      #1 chk("mr_outputs", {gnt_o, data_ready_o, result_valid_o, result_o, result_id_o, busy_o, pc_operand_o}, 0);
      #3 rst_n = 1;
      data_valid_i = '0;
      repeat (5) begin
         tick();
         chk("mr_no_result", {result_valid_o, busy_o}, 0);
      end
      req_i = '1;
      req_len_i[0] = LW'(1);
      req_len_i[1] = LW'(1);
      data_i[0] = 32'h1;
      data_i[1] = 32'h1;
      data_valid_i = '1;
      tick();
      chk("mr_fresh_gnt", gnt_o, 2'b01);
      req_i = '0;
      begin
         int cyc = 0;
         while (!result_valid_o && cyc < 20) begin
            tick();
            cyc++;
         end
      end
      chk("mr_fresh_result", {result_valid_o, result_o}, {1'b1, AW'(1)});
      result_ready_i = 1;
      tick();
      result_ready_i = 0;
      data_valid_i = '0;

      // randomized traffic against a burst-level reference model
      do_reset();
      begin
         logic [31:0] wq[N][16];
         int          blen[N], sent[N];
         logic [N-1:0] active = '0, hv;
         logic        granted = 0, checked = 0, rdone;
         int          ptr = 0, gid = 0, done_cnt = 0, w, want, sum;
         for (int r = 0; r < N; r++) begin
            blen[r] = 0;
            sent[r] = 0;
         end
         for (int c = 0; c < 3000; c++) begin
            hv = data_ready_o & data_valid_i;
            rdone = result_valid_o & result_ready_i;
            tick();
            for (int r = 0; r < N; r++) if (hv[r]) sent[r]++;
            chk("rnd_invariants", {$onehot0(gnt_o), $onehot0(data_ready_o), busy_o == (gnt_o != 0),
                (data_ready_o & ~gnt_o) == 0}, 4'b1111);
            if (rdone) begin
               ptr = (gid + 1) % N;
               active[gid] = 0;
               granted = 0;
               checked = 0;
               done_cnt++;
            end
            if (!granted && gnt_o != 0) begin
               w = winner(req_i, ptr);
               chk("rnd_gnt", gnt_o, N'(1) << w);
               gid = w;
               granted = 1;
               req_i[w] = 0;
            end
            if (granted && result_valid_o && !checked) begin
               want = blen[gid] > ML ? ML : blen[gid];
               sum = 0;
               for (int k = 0; k < want; k++) sum += $countones(wq[gid][k]);
               chk("rnd_result", result_o, sum);
               chk("rnd_id", result_id_o, gid);
               chk("rnd_words", sent[gid], want);
               checked = 1;
            end
            for (int r = 0; r < N; r++) begin
               if (!active[r] && $urandom_range(3) == 0) begin
                  active[r] = 1;
                  req_i[r] = 1;
                  blen[r] = $urandom_range(15);
                  req_len_i[r] = LW'(blen[r]);
                  sent[r] = 0;
                  for (int k = 0; k < 16; k++) wq[r][k] = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
               end
               data_valid_i[r] = $urandom_range(3) != 0;
               data_i[r] = sent[r] < 16 ? wq[r][sent[r]] : $urandom;
            end
            result_ready_i = $urandom_range(1) != 0;
         end
         chk("rnd_progress", done_cnt > 50, 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
